// File: rtl/load_align_extender.sv
// Load-data aligner/extender for the MEM/WB path: lane select, sign/zero extend,
// alignment check, then a STAGES-deep valid/ready pipeline with flush.
module load_align_extender #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1,
    parameter int BIG_ENDIAN = 0,
    parameter int OFS_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [OFS_W-1:0]      i_offset,
    input  logic [1:0]            i_size,
    input  logic                  type_select,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_Q,
    output logic                  o_misaligned
);

    localparam int NBYTES = DATA_WIDTH / 8;
    // Two spare bits let a big-endian start that goes "negative" wrap to a
    // value large enough to shift the whole word out, yielding a zero field.
    localparam int SW = OFS_W + 2;

    logic [DATA_WIDTH-1:0] ext_by_size [4];
    logic [3:0]            bad_by_size;
    logic [DATA_WIDTH-1:0] in_q;
    logic                  in_bad;

    genvar gi;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_size
            localparam int FW = 8 << gi;
            if (FW > DATA_WIDTH) begin : g_illegal
                assign ext_by_size[gi] = '0;
                assign bad_by_size[gi] = 1'b1;
            end else begin : g_legal
                localparam logic [SW-1:0] BE_BASE = SW'(NBYTES - (1 << gi));
                logic [SW-1:0]         start_byte;
                logic [DATA_WIDTH-1:0] shifted;

                assign start_byte = (BIG_ENDIAN != 0) ? (BE_BASE - SW'(i_offset))
                                                      : SW'(i_offset);
                assign shifted    = i_A >> {start_byte, 3'b000};

                if (FW == DATA_WIDTH) begin : g_full
                    assign ext_by_size[gi] = shifted;
                end else begin : g_part
                    logic [FW-1:0] field;
                    assign field           = shifted[FW-1:0];
                    assign ext_by_size[gi] = {{(DATA_WIDTH - FW){type_select & field[FW-1]}}, field};
                end

                if (gi == 0) begin : g_byte
                    assign bad_by_size[gi] = 1'b0;
                end else begin : g_wide
                    assign bad_by_size[gi] = |i_offset[gi-1:0];
                end
            end
        end
    endgenerate

    assign in_bad = bad_by_size[i_size];
    assign in_q   = in_bad ? '0 : ext_by_size[i_size];

    logic [STAGES-1:0]     valid_reg;
    logic [STAGES-1:0]     mis_reg;
    logic [DATA_WIDTH-1:0] q_reg [STAGES];
    logic [STAGES-1:0]     load;
    logic [STAGES-1:0]     up_valid;
    logic [STAGES-1:0]     up_mis;
    logic [DATA_WIDTH-1:0] up_q [STAGES];

    // Unrolled form of "empty or consumer loads": stage k can load unless it
    // and every stage after it are full while the output is stalled.
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            assign load[gi] = i_ready | ~(&valid_reg[STAGES-1:gi]);
            if (gi == 0) begin : g_head
                assign up_valid[gi] = i_valid;
                assign up_mis[gi]   = in_bad;
                assign up_q[gi]     = in_q;
            end else begin : g_body
                assign up_valid[gi] = valid_reg[gi-1];
                assign up_mis[gi]   = mis_reg[gi-1];
                assign up_q[gi]     = q_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            valid_reg <= '0;
            mis_reg   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                q_reg[k] <= '0;
            end
        end else if (i_flush) begin
            valid_reg <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_reg[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        q_reg[k]   <= up_q[k];
                        mis_reg[k] <= up_mis[k];
                    end
                end
            end
        end
    end

    assign o_ready      = load[0];
    assign o_valid      = valid_reg[STAGES-1];
    assign o_Q          = q_reg[STAGES-1];
    assign o_misaligned = mis_reg[STAGES-1];

endmodule

// File: tb/tb_load_align_extender.sv
// Directed bench: lane/extension vectors on 32-bit LE/BE and 64-bit instances,
// then backpressure, flush and mid-stream reset on a two-stage instance.
module tb_load_align_extender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Shared controls for the single-stage instances a (LE), b (BE), c (64-bit)
    logic        rst, valid, ts;
    logic [1:0]  sz, off;
    logic [31:0] a32;
    logic [63:0] a64;
    logic [2:0]  off64;

    logic        a_ready, a_valid, a_mis, b_ready, b_valid, b_mis, c_ready, c_valid, c_mis;
    logic [31:0] a_q, b_q;
    logic [63:0] c_q;

    load_align_extender #(.DATA_WIDTH(32), .STAGES(1), .BIG_ENDIAN(0)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_flush(1'b0), .i_valid(valid), .o_ready(a_ready),
        .i_A(a32), .i_offset(off), .i_size(sz), .type_select(ts),
        .o_valid(a_valid), .i_ready(1'b1), .o_Q(a_q), .o_misaligned(a_mis));

    load_align_extender #(.DATA_WIDTH(32), .STAGES(1), .BIG_ENDIAN(1)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_flush(1'b0), .i_valid(valid), .o_ready(b_ready),
        .i_A(a32), .i_offset(off), .i_size(sz), .type_select(ts),
        .o_valid(b_valid), .i_ready(1'b1), .o_Q(b_q), .o_misaligned(b_mis));

    load_align_extender #(.DATA_WIDTH(64), .STAGES(1), .BIG_ENDIAN(0)) dut_c (
        .i_CLK(clk), .i_RST(rst), .i_flush(1'b0), .i_valid(valid), .o_ready(c_ready),
        .i_A(a64), .i_offset(off64), .i_size(sz), .type_select(ts),
        .o_valid(c_valid), .i_ready(1'b1), .o_Q(c_q), .o_misaligned(c_mis));

    // Two-stage instance for handshake tests
    logic        d_rst, d_flush, d_valid, d_ready, d_ts, d_oready, d_ovalid, d_mis;
    logic [1:0]  d_sz, d_off;
    logic [31:0] d_a, d_q;

    load_align_extender #(.DATA_WIDTH(32), .STAGES(2), .BIG_ENDIAN(0)) dut_d (
        .i_CLK(clk), .i_RST(d_rst), .i_flush(d_flush), .i_valid(d_valid), .o_ready(d_oready),
        .i_A(d_a), .i_offset(d_off), .i_size(d_sz), .type_select(d_ts),
        .o_valid(d_ovalid), .i_ready(d_ready), .o_Q(d_q), .o_misaligned(d_mis));

    task automatic vec(input logic [31:0] a, input logic [1:0] o, input logic [1:0] s,
                       input logic t, input logic [63:0] w, input logic [2:0] o64);
        a32 = a; off = o; sz = s; ts = t; a64 = w; off64 = o64; valid = 1'b1;
        tick();
        valid = 1'b0;
        $display("vec a=0x%08h off=%0d size=%0d ts=%0d -> a_q=0x%08h b_q=0x%08h c_q=0x%016h",
                 a, o, s, t, a_q, b_q, c_q);
    endtask

    task automatic d_req(input logic [31:0] a, input logic [1:0] o, input logic [1:0] s, input logic t);
        d_a = a; d_off = o; d_sz = s; d_ts = t; d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
    endtask

    logic [31:0] req [5];
    int          sent, rcvd;
    bit          saw_block, stall_prev;
    logic [31:0] held;

    initial begin
        rst = 1'b1; valid = 1'b0; ts = 1'b0; sz = 2'd0; off = 2'd0;
        a32 = '0; a64 = '0; off64 = '0;
        d_rst = 1'b1; d_flush = 1'b0; d_valid = 1'b0; d_ready = 1'b1;
        d_ts = 1'b0; d_sz = 2'd0; d_off = 2'd0; d_a = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0; d_rst = 1'b0;

        check("rst_valid", a_valid, 0);
        check("rst_q", a_q, 0);
        check("rst_ready", a_ready, 1);

        vec(32'h1234_5680, 2'd0, 2'd0, 1'b1, 64'h0, 3'd0);
        check("byte_s_valid", a_valid, 1);
        check("byte_s", a_q, 32'hFFFF_FF80);
        check("byte_s_mis", a_mis, 0);
        check("be_byte", b_q, 32'h0000_0012);

        vec(32'h1234_5680, 2'd0, 2'd0, 1'b0, 64'h0, 3'd0);
        check("byte_z", a_q, 32'h0000_0080);

        vec(32'h8001_7FFE, 2'd2, 2'd1, 1'b1, 64'h0, 3'd0);
        check("half_off2", a_q, 32'hFFFF_8001);
        check("be_half_off2", b_q, 32'h0000_7FFE);

        vec(32'h8001_7FFE, 2'd0, 2'd1, 1'b1, 64'h0, 3'd0);
        check("half_off0", a_q, 32'h0000_7FFE);
        check("be_half_off0", b_q, 32'hFFFF_8001);

        vec(32'h8001_7FFE, 2'd1, 2'd1, 1'b1, 64'h0, 3'd0);
        check("half_mis", a_mis, 1);
        check("half_mis_q", a_q, 0);
        check("be_half_mis", b_mis, 1);

        vec(32'h8001_7FFE, 2'd2, 2'd2, 1'b1, 64'h0, 3'd0);
        check("word_mis", a_mis, 1);

        vec(32'h8001_7FFE, 2'd0, 2'd3, 1'b1, 64'h8765_4321_0FED_CBA9, 3'd0);
        check("dword_illegal", a_mis, 1);
        check("dword_illegal_q", a_q, 0);
        check("dw64_full", c_q, 64'h8765_4321_0FED_CBA9);
        check("dw64_full_mis", c_mis, 0);

        vec(32'h8000_0001, 2'd0, 2'd2, 1'b1, 64'h8765_4321_0FED_CBA9, 3'd4);
        check("word_full", a_q, 32'h8000_0001);
        check("dw64_word_hi", c_q, 64'hFFFF_FFFF_8765_4321);

        tick();
        check("idle_valid", a_valid, 0);

        // Backpressure stream, i_ready low for cycles 2..5
        req[0] = 32'hA1A1_A1A1; req[1] = 32'hB2B2_B2B2; req[2] = 32'hC3C3_C3C3;
        req[3] = 32'hD4D4_D4D4; req[4] = 32'hE5E5_E5E5;
        sent = 0; rcvd = 0; saw_block = 0; stall_prev = 0; held = '0;
        d_sz = 2'd2; d_off = 2'd0; d_ts = 1'b0;
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            d_ready = !(cyc >= 2 && cyc <= 5);
            d_valid = (sent < 5);
            d_a     = (sent < 5) ? req[sent] : 32'h0;
            #1;
            if (stall_prev) check("stall_hold", d_q, held);
            if (!d_oready) saw_block = 1;
            if (d_ovalid && d_ready) begin
                check($sformatf("stream_out%0d", rcvd), d_q, req[rcvd]);
                $display("stream cyc=%0d out%0d q=0x%08h", cyc, rcvd, d_q);
                rcvd++;
            end
            stall_prev = d_ovalid && !d_ready;
            held       = d_q;
            if (d_valid && d_oready) sent++;
            tick();
        end
        d_valid = 1'b0;
        check("stream_count", rcvd, 5);
        check("stream_blocked", saw_block, 1);
        tick();
        check("stream_drained", d_ovalid, 0);

        // Flush: two held entries plus a transfer in the flush cycle
        d_ready = 1'b0;
        d_req(32'h1111_1111, 2'd0, 2'd2, 1'b0);
        d_req(32'h2222_2222, 2'd0, 2'd2, 1'b0);
        d_ready = 1'b1; d_flush = 1'b1; d_valid = 1'b1; d_a = 32'h3333_3333;
        #1;
        check("flush_xfer_ready", d_oready, 1);
        tick();
        d_flush = 1'b0; d_valid = 1'b0;
        check("flush_valid", d_ovalid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush_no_ghost", d_ovalid, 0);
        end
        d_req(32'h1234_5680, 2'd0, 2'd0, 1'b1);
        check("post_flush_lat1", d_ovalid, 0);
        tick();
        check("post_flush_valid", d_ovalid, 1);
        check("post_flush_q", d_q, 32'hFFFF_FF80);
        $display("flush new request q=0x%08h", d_q);

        // Reset with full pipeline and output stalled
        d_ready = 1'b0;
        tick();
        d_req(32'h1357_2468, 2'd0, 2'd2, 1'b0);
        d_req(32'h8001_7FFE, 2'd1, 2'd1, 1'b1);
        check("full_ready", d_oready, 0);
        check("full_valid", d_ovalid, 1);
        d_rst = 1'b1; d_valid = 1'b1;
        tick();
        d_rst = 1'b0; d_valid = 1'b0;
        check("mrst_valid", d_ovalid, 0);
        check("mrst_q", d_q, 0);
        check("mrst_mis", d_mis, 0);
        check("mrst_ready", d_oready, 1);
        d_ready = 1'b1;
        d_req(32'h8001_7FFE, 2'd2, 2'd1, 1'b0);
        tick();
        check("post_rst_valid", d_ovalid, 1);
        check("post_rst_q", d_q, 32'h0000_8001);
        check("post_rst_mis", d_mis, 0);
        $display("reset new request q=0x%08h", d_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
